// File: rtl/direct_mapped_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped cache controller.
// Address split: | tag | index | 2-bit byte offset |.
package cache_pkg;

    localparam int          OFFSET_W  = 2;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_MEM_WR,
        S_RESP
    } ctrl_state_t;

    // The caller truncates the result to its own index/tag width.
    function automatic logic [63:0] get_index(input logic [63:0] addr, input int index_w);
        return (addr >> OFFSET_W) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr, input int index_w);
        return addr >> (index_w + OFFSET_W);
    endfunction

endpackage

// File: rtl/direct_mapped_ctrl_if.sv
// CPU load/store port, memory bus and statistics of the cache controller.
// slave = controller side, master = CPU/memory environment side.
interface direct_mapped_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_is_write;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_resp_valid;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport slave (
        input  cpu_req_valid, cpu_addr, cpu_is_write, cpu_wdata, mem_ack, mem_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_hit, cpu_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    modport master (
        output cpu_req_valid, cpu_addr, cpu_is_write, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_hit, cpu_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/direct_mapped_ctrl_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// one write port, valid bits cleared synchronously on reset.
module cache_line_array #(
    parameter int CACHE_SIZE = 64,
    parameter int INDEX_W    = 6,
    parameter int TAG_W      = 24,
    parameter int DATA_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i
);
    logic [CACHE_SIZE-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [CACHE_SIZE];
    logic [DATA_W-1:0]     data_q [CACHE_SIZE];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/direct_mapped_ctrl.sv
// Write-through, write-allocate, direct-mapped cache sequencer with
// saturating hit/miss statistics.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a CPU request
// LOOKUP   | compare tag, count hit/miss, install line on writes
// MEM_RD   | fill read outstanding on the memory bus
// MEM_WR   | write-through outstanding on the memory bus
// RESP     | one-cycle response to the CPU
module direct_mapped_ctrl
    import cache_pkg::*;
#(
    parameter int CACHE_SIZE = 64,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic clk,
    input  logic reset,
    direct_mapped_ctrl_if.slave bus
);
    localparam int INDEX_W = $clog2(CACHE_SIZE);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_write_q, is_write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               lk_valid;
    logic [TAG_W-1:0]   lk_tag;
    logic [DATA_W-1:0]  lk_data;
    logic               lookup_hit;
    logic               arr_we;
    logic [DATA_W-1:0]  arr_data;

    assign index      = INDEX_W'(get_index(64'(addr_q), INDEX_W));
    assign tag        = TAG_W'(get_tag(64'(addr_q), INDEX_W));
    assign lookup_hit = lk_valid && (lk_tag == tag);

    cache_line_array #(
        .CACHE_SIZE (CACHE_SIZE),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_index_i (index),
        .rd_valid_o (lk_valid),
        .rd_tag_o   (lk_tag),
        .rd_data_o  (lk_data),
        .wr_en_i    (arr_we),
        .wr_index_i (index),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        hit_d      = hit_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        arr_we     = 1'b0;
        arr_data   = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cpu_req_valid) begin
                    addr_d     = bus.cpu_addr;
                    is_write_d = bus.cpu_is_write;
                    wdata_d    = bus.cpu_wdata;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lookup_hit;
                if (lookup_hit) begin
                    hit_cnt_d = (hit_cnt_q == COUNT_MAX) ? hit_cnt_q : hit_cnt_q + 32'd1;
                end else begin
                    miss_cnt_d = (miss_cnt_q == COUNT_MAX) ? miss_cnt_q : miss_cnt_q + 32'd1;
                end
                if (is_write_q) begin
                    // Write-allocate without fill: the whole line is the written word.
                    arr_we  = 1'b1;
                    rdata_d = '0;
                    state_d = S_MEM_WR;
                end else if (lookup_hit) begin
                    rdata_d = lk_data;
                    state_d = S_RESP;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (bus.mem_ack) begin
                    arr_we   = 1'b1;
                    arr_data = bus.mem_rdata;
                    rdata_d  = bus.mem_rdata;
                    state_d  = S_RESP;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ack) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cpu_req_ready  = (state_q == S_IDLE);
    assign bus.cpu_resp_valid = (state_q == S_RESP);
    assign bus.cpu_hit        = (state_q == S_RESP) && hit_q;
    assign bus.cpu_rdata      = (state_q == S_RESP) ? rdata_q : '0;
    assign bus.mem_req        = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign bus.mem_we         = (state_q == S_MEM_WR);
    assign bus.mem_addr       = bus.mem_req ? {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
    assign bus.mem_wdata      = (state_q == S_MEM_WR) ? wdata_q : '0;
    assign bus.hit_count      = hit_cnt_q;
    assign bus.miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_direct_mapped_ctrl.sv
// Bench for direct_mapped_ctrl: directed requests against a behavioural cache
// model, with a per-cycle compare process and literal spot checks.
module tb_direct_mapped_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    direct_mapped_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifc();

    direct_mapped_ctrl #(.CACHE_SIZE(64), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cache model: 64 lines, tag = addr[31:8], index = addr[7:2]
    bit          mvalid [64];
    logic [23:0] mtag   [64];
    logic [31:0] mdata  [64];
    int          m_hits   = 0;
    int          m_misses = 0;

    bit          exp_pending    = 0;
    bit          exp_mem_active = 0;
    bit          exp_mem_we     = 0;
    logic [31:0] exp_mem_addr   = 0;
    logic [31:0] exp_mem_wdata  = 0;
    bit          exp_hit        = 0;
    logic [31:0] exp_rdata      = 0;
    int          exp_resp_cyc   = 0;
    bit          aborting       = 0;

    int          resp_cnt   = 0;
    logic        last_hit   = 0;
    logic [31:0] last_rdata = 0;

    int          mem_lat   = 1;
    logic [31:0] mem_fill  = 0;
    bit          mem_auto  = 1;
    int          pulse_req = 0;
    int          mem_txn   = 0;

    // memory responder: ack on the mem_lat-th cycle of mem_req, or a stray pulse on request
    initial begin
        int mcnt;
        int pulse_done;
        mcnt = 0;
        pulse_done = 0;
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ifc.mem_ack) begin
                ifc.mem_ack = 1'b0;
                mcnt = 0;
            end else if (pulse_req != pulse_done) begin
                ifc.mem_ack   = 1'b1;
                ifc.mem_rdata = 32'hDEAD_BEEF;
                pulse_done    = pulse_req;
            end else if (ifc.mem_req && mem_auto) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    ifc.mem_ack   = 1'b1;
                    ifc.mem_rdata = mem_fill;
                    mem_txn++;
                end
            end
        end
    end

    // per-cycle compare against the model's expectations
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ifc.cpu_resp_valid) begin
                    chk("resp_expected", 32'(exp_pending), 32'd1);
                    if (exp_pending) begin
                        chk("resp_cycle", 32'(cyc), 32'(exp_resp_cyc));
                        chk("resp_hit", 32'(ifc.cpu_hit), 32'(exp_hit));
                        chk("resp_rdata", ifc.cpu_rdata, exp_rdata);
                        chk("hit_count", ifc.hit_count, 32'(m_hits));
                        chk("miss_count", ifc.miss_count, 32'(m_misses));
                    end
                    last_hit   = ifc.cpu_hit;
                    last_rdata = ifc.cpu_rdata;
                    resp_cnt++;
                end
                if (ifc.mem_req) begin
                    chk("mem_req_expected", 32'(exp_mem_active), 32'd1);
                    if (exp_mem_active) begin
                        chk("mem_we", 32'(ifc.mem_we), 32'(exp_mem_we));
                        chk("mem_addr", ifc.mem_addr, exp_mem_addr);
                        if (exp_mem_we) chk("mem_wdata", ifc.mem_wdata, exp_mem_wdata);
                    end
                end
                if (!exp_pending && !aborting) begin
                    chk("idle_ready", 32'(ifc.cpu_req_ready), 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         output int n);
        int k;
        k = 0;
        @(negedge clk);
        while (!ifc.cpu_req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ifc.cpu_req_ready) chk("ready_timeout", 32'(ifc.cpu_req_ready), 32'd1);
        ifc.cpu_req_valid = 1'b1;
        ifc.cpu_addr      = addr;
        ifc.cpu_is_write  = we;
        ifc.cpu_wdata     = wdata;
        n = cyc;
        @(posedge clk);
        #1;
        ifc.cpu_req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input int lat, input logic [31:0] fill);
        int idx;
        bit h;
        int n;
        int start;
        idx = int'(addr[7:2]);
        h   = mvalid[idx] && (mtag[idx] == addr[31:8]);
        exp_hit        = h;
        exp_rdata      = we ? 32'd0 : (h ? mdata[idx] : fill);
        exp_mem_active = we || !h;
        exp_mem_we     = we;
        exp_mem_addr   = {addr[31:2], 2'b00};
        exp_mem_wdata  = wdata;
        if (h) m_hits++;
        else   m_misses++;
        if (we || !h) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = addr[31:8];
            mdata[idx]  = we ? wdata : fill;
        end
        mem_lat  = lat;
        mem_fill = fill;
        start    = resp_cnt;
        issue(addr, we, wdata, n);
        exp_resp_cyc = (!we && h) ? n + 2 : n + 2 + lat;
        exp_pending  = 1'b1;
        for (int k = 0; k < 100 && resp_cnt == start; k++) @(posedge clk);
        if (resp_cnt == start) chk("resp_timeout", 32'(resp_cnt), 32'(start + 1));
        exp_pending    = 1'b0;
        exp_mem_active = 1'b0;
    endtask

    localparam logic [31:0] A5 = 32'h0AAA_AA14;
    localparam logic [31:0] B5 = 32'h0BBB_BB14;
    localparam logic [31:0] C5 = 32'h0CCC_CC14;

    initial begin
        int txn0;
        int n;
        int start;
        ifc.cpu_req_valid = 1'b0;
        ifc.cpu_addr      = '0;
        ifc.cpu_is_write  = 1'b0;
        ifc.cpu_wdata     = '0;
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ifc.cpu_req_ready), 32'd1);
        chk("rst_mem_req", 32'(ifc.mem_req), 32'd0);
        chk("rst_resp_valid", 32'(ifc.cpu_resp_valid), 32'd0);
        chk("rst_hit_count", ifc.hit_count, 32'd0);
        chk("rst_miss_count", ifc.miss_count, 32'd0);

        txn0 = mem_txn;
        for (int i = 0; i < 64; i++) begin
            do_req(32'({20'hAAAAA, 6'(i), 2'b00}), 1'b1, 32'hAB00 + 32'(i), 3, 32'h0);
        end
        chk("fill_miss_count", ifc.miss_count, 32'd64);
        chk("fill_hit_count", ifc.hit_count, 32'd0);
        chk("fill_mem_writes", 32'(mem_txn - txn0), 32'd64);
        chk("fill_last_hit", 32'(last_hit), 32'd0);

        txn0 = mem_txn;
        do_req(A5, 1'b0, 32'h0, 3, 32'h0);
        chk("a5_hit", 32'(last_hit), 32'd1);
        chk("a5_rdata", last_rdata, 32'hAB05);
        chk("a5_no_mem", 32'(mem_txn - txn0), 32'd0);

        do_req(B5, 1'b0, 32'h0, 2, 32'hBB05);
        chk("b5_hit", 32'(last_hit), 32'd0);
        chk("b5_rdata", last_rdata, 32'hBB05);
        chk("b5_fill", 32'(mem_txn - txn0), 32'd1);
        do_req(B5, 1'b0, 32'h0, 2, 32'h0);
        chk("b5_reread_hit", 32'(last_hit), 32'd1);
        chk("b5_reread_rdata", last_rdata, 32'hBB05);

        do_req(C5, 1'b1, 32'hCC55, 1, 32'h0);
        chk("c5_write_hit", 32'(last_hit), 32'd0);
        chk("c5_write_rdata", last_rdata, 32'd0);
        do_req(C5, 1'b0, 32'h0, 1, 32'h0);
        chk("c5_read_hit", 32'(last_hit), 32'd1);
        chk("c5_read_rdata", last_rdata, 32'hCC55);
        txn0 = mem_txn;
        do_req(B5, 1'b0, 32'h0, 1, 32'hBB05);
        chk("b5_evicted_hit", 32'(last_hit), 32'd0);
        chk("b5_evicted_fill", 32'(mem_txn - txn0), 32'd1);
        chk("seq_hit_count", ifc.hit_count, 32'd3);
        chk("seq_miss_count", ifc.miss_count, 32'd67);

        // abort a fill read with reset in its second MEM_RD cycle
        mem_auto       = 1'b0;
        aborting       = 1'b1;
        exp_mem_active = 1'b1;
        exp_mem_we     = 1'b0;
        exp_mem_addr   = 32'h0DDD_DD24;
        issue(32'h0DDD_DD24, 1'b0, 32'h0, n);
        exp_pending = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_mem_req_up", 32'(ifc.mem_req), 32'd1);
        @(negedge clk);
        reset          = 1'b1;
        exp_pending    = 1'b0;
        exp_mem_active = 1'b0;
        @(negedge clk);
        chk("abort_mem_req_drop", 32'(ifc.mem_req), 32'd0);
        reset = 1'b0;
        start = resp_cnt;
        @(negedge clk);
        pulse_req++;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", 32'(resp_cnt), 32'(start));
        chk("abort_mem_req_idle", 32'(ifc.mem_req), 32'd0);
        chk("abort_hit_count", ifc.hit_count, 32'd0);
        chk("abort_miss_count", ifc.miss_count, 32'd0);
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        mem_auto = 1'b1;
        aborting = 1'b0;

        do_req(32'hAAAA_A014, 1'b0, 32'h0, 2, 32'h1234);
        chk("post_rst_hit", 32'(last_hit), 32'd0);
        chk("post_rst_rdata", last_rdata, 32'h1234);
        chk("post_rst_miss_count", ifc.miss_count, 32'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
